lut_stream_sequencer: RTL and testbench

- Sequences readout of character strings from the Laplace lookup-table ROM and streams them one byte at a time over a valid/ready interface toward the pin-output stage.
- A start command selects a string slot. The block fetches the length header, then fetches and emits each character.
- It exposes chars_remaining and which_state as debug/status outputs for the top-level wrapper.

---
 rtl/lut_stream_sequencer.sv | 134 +++++++++++++
 tb/tb_lut_stream_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lut_stream_sequencer.sv
// Streams a length-prefixed string from a LUT slot one byte at a time over valid/ready.
// First byte 5 cycles after start, 3 cycles per byte after that; out_data holds while out_ready is low.
module lut_stream_sequencer #(
    parameter int SLOT_W = 4,
    parameter int SEL_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    start,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    abort,
    output logic [SEL_W+SLOT_W-1:0] lut_addr,
    input  logic [DATA_W-1:0]       lut_data,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              chars_remaining,
    output logic [3:0]              which_state
);
    localparam int AW = SEL_W + SLOT_W;
    localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'((1 << SLOT_W) - 1);
    localparam logic [SLOT_W-1:0] IDX_MAX = '1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LEN_REQ  = 4'd1;
    localparam logic [3:0] S_LEN_WAIT = 4'd2;
    localparam logic [3:0] S_CHR_REQ  = 4'd3;
    localparam logic [3:0] S_CHR_WAIT = 4'd4;
    localparam logic [3:0] S_EMIT     = 4'd5;
    localparam logic [3:0] S_DONE     = 4'd6;

    logic [3:0]        state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic [7:0]        rem_q, rem_d;
    logic [DATA_W-1:0] len_clamped;

    // Headers longer than a slot can hold are clamped so the address stays inside the slot.
    assign len_clamped = (lut_data > MAX_LEN) ? MAX_LEN : lut_data;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rem_d       = rem_q;
        done_d      = ena ? 1'b0 : done_q;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_d  = {sel, {SLOT_W{1'b0}}};
                        state_d = S_LEN_REQ;
                    end
                end
                S_LEN_REQ:  state_d = S_LEN_WAIT;
                S_LEN_WAIT: begin
                    rem_d = 8'(len_clamped);
                    if (len_clamped == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = {addr_q[AW-1:SLOT_W], SLOT_W'(1)};
                        state_d = S_CHR_REQ;
                    end
                end
                S_CHR_REQ:  state_d = S_CHR_WAIT;
                S_CHR_WAIT: begin
                    out_data_d  = lut_data;
                    out_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end
                S_EMIT: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        rem_d       = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            if (addr_q[SLOT_W-1:0] != IDX_MAX) begin
                                addr_d = addr_q + AW'(1);
                            end
                            state_d = S_CHR_REQ;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            // Abort wins over a same-cycle handshake: the byte is treated as not accepted.
            if (abort && state_q != S_IDLE) begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                rem_d       = 8'd0;
                done_d      = 1'b0;
                addr_d      = addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            rem_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            rem_q       <= rem_d;
        end
    end

    assign lut_addr        = addr_q;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign done            = done_q;
    assign chars_remaining = rem_q;
    assign which_state     = state_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_lut_stream_sequencer.sv
// Bench for lut_stream_sequencer: timing, backpressure, clamp, abort and random streams vs a string model.
module tb_lut_stream_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic [3:0] sel = 4'd0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] lut_addr;
    logic [7:0] lut_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [7:0] chars_remaining;
    logic [3:0] which_state;

    logic [7:0] rom [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) lut_data <= rom[lut_addr];

    lut_stream_sequencer #(.SLOT_W(4), .SEL_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sel(sel), .abort(abort),
        .lut_addr(lut_addr), .lut_data(lut_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .chars_remaining(chars_remaining),
        .which_state(which_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_len(input logic [3:0] s);
        int h;
        h = int'(rom[{s, 4'h0}]);
        return (h > 15) ? 15 : h;
    endfunction

    function automatic logic [7:0] adr(input logic [3:0] s, input int i);
        return {s, 4'(i)};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, lut_addr, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rem"}, chars_remaining, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_state"}, which_state, 0);
    endtask

    // Cycle-exact run with ena=1 and out_ready=1: byte i valid at cycle 5+3i, done at 3+3L.
    task automatic latency_run(input logic [3:0] s);
        int L, dc, ci;
        bit vcyc;
        L  = exp_len(s);
        dc = 3 + 3 * L;
        @(posedge clk); #1;
        start = 1'b1; sel = s; ena = 1'b1; out_ready = 1'b1; abort = 1'b0;
        for (int k = 0; k <= dc + 1; k++) begin
            @(negedge clk);
            vcyc = (k >= 5) && (k < dc) && ((k - 5) % 3 == 0);
            check("lat_valid", out_valid, vcyc);
            check("lat_done", done, (k == dc));
            check("lat_busy", busy, (k >= 1) && (k <= dc));
            if (vcyc) begin
                ci = (k - 5) / 3;
                check("lat_data", out_data, rom[adr(s, ci + 1)]);
                check("lat_rem", chars_remaining, L - ci);
            end
            if (k == 1) check("lat_addr_hdr", lut_addr, adr(s, 0));
            if (L > 0 && k >= 3 && k < dc && k % 3 == 0) check("lat_addr_chr", lut_addr, adr(s, k / 3));
            if (k == dc) check("lat_rem_end", chars_remaining, 0);
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    // mode 0: ready high; 1: 4 stall cycles on first byte; 2: random ready and ena.
    task automatic run_string(input logic [3:0] s, input int mode, input int abort_idx);
        int L, hs, dones, stall, cyc;
        logic [7:0] q[$];
        logic [7:0] prev_data, prev_rem;
        bit prev_stall, fin, aborted;
        L = exp_len(s);
        hs = 0; dones = 0; stall = 0; cyc = 0;
        prev_stall = 1'b0; fin = 1'b0; aborted = 1'b0;
        prev_data = 8'd0; prev_rem = 8'd0;
        for (int i = 1; i <= L; i++) q.push_back(rom[adr(s, i)]);
        @(posedge clk); #1;
        start = 1'b1; sel = s; ena = 1'b1; out_ready = 1'b1; abort = 1'b0;
        while (!fin && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                check("rs_hold_data", out_data, prev_data);
                check("rs_hold_rem", chars_remaining, prev_rem);
            end
            if (done && ena) begin
                dones++;
                fin = 1'b1;
            end
            if (!abort && out_valid && out_ready && ena) begin
                check("rs_data", out_data, (q.size() > 0) ? q.pop_front() : 8'hxx);
                check("rs_rem", chars_remaining, L - hs);
                hs++;
            end
            prev_stall = out_valid && !(out_ready && ena) && !abort;
            prev_data  = out_data;
            prev_rem   = chars_remaining;
            @(posedge clk); #1;
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                aborted = 1'b1;
                fin = 1'b1;
                check("ab_state", which_state, 0);
                check("ab_valid", out_valid, 0);
                check("ab_rem", chars_remaining, 0);
                check("ab_done", done, 0);
            end else begin
                case (mode)
                    1: begin
                        if (out_valid && hs == 0 && stall < 4) begin
                            out_ready = 1'b0;
                            stall++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                    2: begin
                        out_ready = 1'($urandom_range(0, 1));
                        ena = ($urandom_range(0, 3) != 0);
                    end
                    default: begin
                        out_ready = 1'b1;
                        ena = 1'b1;
                    end
                endcase
                if (abort_idx >= 0 && hs == abort_idx && out_valid) begin
                    abort = 1'b1; out_ready = 1'b1; ena = 1'b1;
                end
            end
        end
        if (!fin) check("rs_timeout", 0, 1);
        ena = 1'b1; out_ready = 1'b1;
        if (aborted) begin
            check("ab_hs", hs, abort_idx);
        end else begin
            check("rs_hs", hs, L);
            check("rs_dones", dones, 1);
            check("rs_left", q.size(), 0);
            if (mode == 1) check("rs_stalls", stall, 4);
        end
        @(negedge clk);
        check("rs_idle_busy", busy, 0);
        check("rs_idle_done", done, 0);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
        for (int s = 0; s < 16; s++) rom[s * 16] = 8'($urandom_range(0, 20));
        rom[8'h20] = 8'd3; rom[8'h21] = 8'h41; rom[8'h22] = 8'h42; rom[8'h23] = 8'h43;
        rom[8'h50] = 8'd0;
        rom[8'hA0] = 8'hFF;

        #12;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        latency_run(4'h2);
        latency_run(4'h5);
        latency_run(4'hA);

        // Asynchronous reset while a byte is waiting for acceptance.
        @(posedge clk); #1;
        start = 1'b1; sel = 4'h2; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("rst_mid_vld", out_valid, 1);
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        run_string(4'h2, 1, -1);
        run_string(4'h2, 0, 1);
        run_string(4'h3, 0, -1);
        run_string(4'hA, 2, -1);
        for (int r = 0; r < 20; r++) begin
            run_string(4'($urandom_range(0, 15)), 2, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
